// File: rtl/buff_uart_host.sv
// Bus master for the buffered UART register port: polls status, drains RX bytes
// into a valid/ready stream and pushes bytes from a valid/ready stream into TX.
module buff_uart_host #(
   parameter int width          = 8,
   parameter int address_width  = 4,
   parameter int rx_address     = 0,
   parameter int tx_address     = 1,
   parameter int status_address = 2,
   parameter int rx_avail_bit   = 0,
   parameter int tx_full_bit    = 1,
   parameter int read_latency   = 1
) (
   input  logic                     clock,
   input  logic                     reset,
   output logic                     read_enable,
   output logic                     write_enable,
   output logic [address_width-1:0] active_address,
   output logic [width-1:0]         bus_wdata,
   input  logic [width-1:0]         bus_rdata,
   input  logic [width-1:0]         tx_data,
   input  logic                     tx_valid,
   output logic                     tx_ready,
   output logic [width-1:0]         rx_data,
   output logic                     rx_valid,
   input  logic                     rx_ready
);

   localparam int CountWidth = (read_latency > 1) ? $clog2(read_latency) : 1;

   typedef enum logic [2:0] {
      STATUS_RD,
      STATUS_WAIT,
      DECIDE,
      RX_RD,
      RX_WAIT,
      TX_WR
   } state_t;

   state_t                   r_state;
   logic [CountWidth-1:0]    r_waitCount;
   logic                     r_statusRxAvail;
   logic                     r_statusTxFull;
   logic [width-1:0]         r_hold;
   logic                     r_holdFull;
   logic                     r_lastServedRx;
   logic                     r_readEnable;
   logic                     r_writeEnable;
   logic [address_width-1:0] r_activeAddress;
   logic [width-1:0]         r_busWdata;
   logic [width-1:0]         r_rxData;
   logic                     r_rxValid;

   logic w_waitDone;
   logic w_rxGo;
   logic w_txGo;
   logic w_serveRx;

   assign w_waitDone = (r_waitCount == CountWidth'(read_latency - 1));
   assign w_rxGo     = r_statusRxAvail && !r_rxValid;
   assign w_txGo     = r_holdFull && !r_statusTxFull;
   // On a tie the side that was not served last goes first.
   assign w_serveRx  = w_rxGo && (!w_txGo || !r_lastServedRx);

   assign read_enable    = r_readEnable;
   assign write_enable   = r_writeEnable;
   assign active_address = r_activeAddress;
   assign bus_wdata      = r_busWdata;
   assign rx_data        = r_rxData;
   assign rx_valid       = r_rxValid;
   assign tx_ready       = !r_holdFull;

   // Strobes are registered and raised on the edge that enters their state, so the
   // reset-time STATUS_RD spends one extra cycle raising its own strobe.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state         <= STATUS_RD;
         r_waitCount     <= '0;
         r_statusRxAvail <= 1'b0;
         r_statusTxFull  <= 1'b0;
         r_hold          <= '0;
         r_holdFull      <= 1'b0;
         r_lastServedRx  <= 1'b0;
         r_readEnable    <= 1'b0;
         r_writeEnable   <= 1'b0;
         r_activeAddress <= address_width'(status_address);
         r_busWdata      <= '0;
         r_rxData        <= '0;
         r_rxValid       <= 1'b0;
      end else begin
         if (r_rxValid && rx_ready) begin
            r_rxValid <= 1'b0;
         end
         if (tx_valid && !r_holdFull) begin
            r_hold     <= tx_data;
            r_holdFull <= 1'b1;
         end

         case (r_state)
            STATUS_RD: begin
               if (r_readEnable) begin
                  r_readEnable <= 1'b0;
                  r_waitCount  <= '0;
                  r_state      <= STATUS_WAIT;
               end else begin
                  r_readEnable    <= 1'b1;
                  r_activeAddress <= address_width'(status_address);
               end
            end
            STATUS_WAIT: begin
               if (w_waitDone) begin
                  r_statusRxAvail <= bus_rdata[rx_avail_bit];
                  r_statusTxFull  <= bus_rdata[tx_full_bit];
                  r_state         <= DECIDE;
               end else begin
                  r_waitCount <= r_waitCount + CountWidth'(1);
               end
            end
            DECIDE: begin
               if (w_serveRx) begin
                  r_readEnable    <= 1'b1;
                  r_activeAddress <= address_width'(rx_address);
                  r_state         <= RX_RD;
               end else if (w_txGo) begin
                  r_writeEnable   <= 1'b1;
                  r_activeAddress <= address_width'(tx_address);
                  r_busWdata      <= r_hold;
                  r_state         <= TX_WR;
               end else begin
                  r_readEnable    <= 1'b1;
                  r_activeAddress <= address_width'(status_address);
                  r_state         <= STATUS_RD;
               end
            end
            RX_RD: begin
               r_readEnable <= 1'b0;
               r_waitCount  <= '0;
               r_state      <= RX_WAIT;
            end
            RX_WAIT: begin
               if (w_waitDone) begin
                  r_rxData        <= bus_rdata;
                  r_rxValid       <= 1'b1;
                  r_lastServedRx  <= 1'b1;
                  r_readEnable    <= 1'b1;
                  r_activeAddress <= address_width'(status_address);
                  r_state         <= STATUS_RD;
               end else begin
                  r_waitCount <= r_waitCount + CountWidth'(1);
               end
            end
            TX_WR: begin
               r_writeEnable   <= 1'b0;
               r_holdFull      <= 1'b0;
               r_lastServedRx  <= 1'b0;
               r_readEnable    <= 1'b1;
               r_activeAddress <= address_width'(status_address);
               r_state         <= STATUS_RD;
            end
            default: begin
               r_readEnable  <= 1'b0;
               r_writeEnable <= 1'b0;
               r_state       <= STATUS_RD;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_buff_uart_host.sv
// Bench for buff_uart_host: a behavioural UART register port, directed scenarios and
// a randomized phase checked against byte-order queues.
module tb_buff_uart_host;

   localparam logic [7:0] KindRead  = 8'h52;
   localparam logic [7:0] KindWrite = 8'h57;

   logic       clock = 1'b0;
   logic       reset;
   logic       readEnable;
   logic       writeEnable;
   logic [3:0] activeAddress;
   logic [7:0] busWdata;
   logic [7:0] busRdata = 8'h00;
   logic [7:0] txData;
   logic       txValid;
   logic       txReady;
   logic [7:0] rxData;
   logic       rxValid;
   logic       rxReady;

   buff_uart_host dut (
      .clock          (clock),
      .reset          (reset),
      .read_enable    (readEnable),
      .write_enable   (writeEnable),
      .active_address (activeAddress),
      .bus_wdata      (busWdata),
      .bus_rdata      (busRdata),
      .tx_data        (txData),
      .tx_valid       (txValid),
      .tx_ready       (txReady),
      .rx_data        (rxData),
      .rx_valid       (rxValid),
      .rx_ready       (rxReady)
   );

   always #5 clock = ~clock;

   int nChecks = 0;
   int nFail   = 0;

   int cyc = 0;
   logic [7:0] uartRxq[$];
   logic       uartTxFull = 1'b0;
   logic [7:0] rxGot[$];
   logic [7:0] txLog[$];
   logic [7:0] accKind[$];
   int statusCycles[$];
   int statusReadCount = 0;
   int rxReadCount = 0;
   int writeCount = 0;
   int lastStatusCyc = 0;
   int dataCyc = 0;
   int dataStatusCyc = 0;
   int rxRiseCyc = 0;
   logic statusSeen = 1'b0;
   logic prevRead = 1'b0;
   logic prevWrite = 1'b0;
   logic prevRxValid = 1'b0;
   logic [7:0] prevRxData = 8'h00;
   logic randomMode = 1'b0;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      nChecks++;
      assert (observed === expected) else begin
         nFail++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Behavioural UART register port with one cycle of read latency.
   always @(posedge clock) begin
      cyc <= cyc + 1;
      if (readEnable) begin
         if (activeAddress == 4'd2)
            busRdata <= {6'b0, uartTxFull, (uartRxq.size() != 0)};
         else if (activeAddress == 4'd0 && uartRxq.size() != 0)
            busRdata <= uartRxq.pop_front();
         else
            busRdata <= 8'h00;
      end
      if (rxValid && rxReady)
         rxGot.push_back(rxData);
   end

   // Bus protocol monitor: strobe shape, poll-before-access and RX stream stability.
   always @(negedge clock) begin
      if (reset) begin
         statusSeen  <= 1'b0;
         prevRead    <= 1'b0;
         prevWrite   <= 1'b0;
         prevRxValid <= rxValid;
      end else begin
         if (readEnable || writeEnable)
            checkOutput("strobes_exclusive", {31'b0, readEnable && writeEnable}, 0);
         if (readEnable)
            checkOutput("read_one_cycle", {31'b0, prevRead}, 0);
         if (writeEnable)
            checkOutput("write_one_cycle", {31'b0, prevWrite}, 0);
         if (readEnable && activeAddress == 4'd2) begin
            statusCycles.push_back(cyc);
            lastStatusCyc   <= cyc;
            statusSeen      <= 1'b1;
            statusReadCount <= statusReadCount + 1;
         end
         if (readEnable && activeAddress != 4'd2) begin
            checkOutput("rx_read_addr", {28'b0, activeAddress}, 0);
            checkOutput("rx_read_after_status", {31'b0, statusSeen}, 1);
            checkOutput("rx_read_fifo_nonempty", {31'b0, uartRxq.size() != 0}, 1);
            statusSeen    <= 1'b0;
            rxReadCount   <= rxReadCount + 1;
            dataCyc       <= cyc;
            dataStatusCyc <= lastStatusCyc;
            accKind.push_back(KindRead);
         end
         if (writeEnable) begin
            checkOutput("write_addr", {28'b0, activeAddress}, 1);
            checkOutput("write_after_status", {31'b0, statusSeen}, 1);
            checkOutput("write_tx_ready_low", {31'b0, txReady}, 0);
            statusSeen    <= 1'b0;
            writeCount    <= writeCount + 1;
            dataCyc       <= cyc;
            dataStatusCyc <= lastStatusCyc;
            txLog.push_back(busWdata);
            accKind.push_back(KindWrite);
         end
         if (rxValid && !prevRxValid)
            rxRiseCyc <= cyc;
         if (rxValid && prevRxValid && !rxReady)
            checkOutput("rx_data_stable", {24'b0, rxData}, {24'b0, prevRxData});
         prevRead    <= readEnable;
         prevWrite   <= writeEnable;
         prevRxValid <= rxValid;
         prevRxData  <= rxData;
      end
   end

   always @(negedge clock) begin
      if (randomMode) begin
         #1;
         rxReady    = ($urandom_range(0, 2) != 0);
         uartTxFull = ($urandom_range(0, 3) == 0);
      end
   end

   task automatic stepNeg();
      @(negedge clock);
      #1;
   endtask

   task automatic pushTx(input logic [7:0] b);
      int n = 0;
      txData  = b;
      txValid = 1'b1;
      while (!txReady && n < 200) begin
         stepNeg();
         n++;
      end
      checkOutput("tx_accept", {31'b0, txReady}, 1);
      @(posedge clock);
      #1;
      txValid = 1'b0;
      stepNeg();
   endtask

   task automatic applyStimulus();
      int preR, preW, preS, kBase, rBase, tBase, n;
      logic [7:0] expRx[$];
      logic [7:0] expTx[$];
      logic [7:0] b;

      reset = 1'b1; txData = 8'h00; txValid = 1'b0; rxReady = 1'b1;
      repeat (3) stepNeg();
      checkOutput("reset_read_enable", {31'b0, readEnable}, 0);
      checkOutput("reset_write_enable", {31'b0, writeEnable}, 0);
      checkOutput("reset_address", {28'b0, activeAddress}, 2);
      checkOutput("reset_wdata", {24'b0, busWdata}, 0);
      checkOutput("reset_rx_data", {24'b0, rxData}, 0);
      checkOutput("reset_rx_valid", {31'b0, rxValid}, 0);
      checkOutput("reset_tx_ready", {31'b0, txReady}, 1);

      $display("[TB] idle polling");
      statusCycles.delete();
      reset = 1'b0;
      repeat (30) stepNeg();
      checkOutput("idle_no_write", writeCount, 0);
      checkOutput("idle_no_rx_read", rxReadCount, 0);
      checkOutput("idle_poll_count", {31'b0, statusCycles.size() >= 9}, 1);
      for (int i = 1; i < statusCycles.size(); i++)
         checkOutput("idle_poll_period", statusCycles[i] - statusCycles[i-1], 3);

      $display("[TB] rx drain");
      preR = rxReadCount;
      uartRxq.push_back(8'hA5);
      n = 0;
      while (!rxValid && n < 50) begin stepNeg(); n++; end
      checkOutput("rx_drain_valid", {31'b0, rxValid}, 1);
      checkOutput("rx_drain_data", {24'b0, rxData}, 32'hA5);
      checkOutput("rx_drain_one_read", rxReadCount - preR, 1);
      checkOutput("rx_latency_from_poll", rxRiseCyc - dataStatusCyc, 5);
      checkOutput("rx_latency_from_read", rxRiseCyc - dataCyc, 2);
      stepNeg();
      checkOutput("rx_drain_consumed", {31'b0, rxValid}, 0);
      checkOutput("rx_drain_got_count", rxGot.size(), 1);
      checkOutput("rx_drain_got_byte", {24'b0, rxGot[0]}, 32'hA5);

      $display("[TB] tx push");
      preW = writeCount;
      pushTx(8'h3C);
      n = 0;
      while (writeCount == preW && n < 30) begin stepNeg(); n++; end
      checkOutput("tx_push_write_count", writeCount - preW, 1);
      checkOutput("tx_push_strobe", {31'b0, writeEnable}, 1);
      checkOutput("tx_push_addr", {28'b0, activeAddress}, 1);
      checkOutput("tx_push_data", {24'b0, busWdata}, 32'h3C);
      checkOutput("tx_push_ready_low", {31'b0, txReady}, 0);
      stepNeg();
      checkOutput("tx_push_ready_back", {31'b0, txReady}, 1);
      checkOutput("tx_push_strobe_drop", {31'b0, writeEnable}, 0);

      $display("[TB] tx full");
      uartTxFull = 1'b1;
      repeat (4) stepNeg();
      pushTx(8'h77);
      preW = writeCount;
      preS = statusReadCount;
      n = 0;
      while (statusReadCount - preS < 10 && n < 100) begin stepNeg(); n++; end
      checkOutput("tx_full_polls", {31'b0, statusReadCount - preS >= 10}, 1);
      checkOutput("tx_full_no_write", writeCount - preW, 0);
      checkOutput("tx_full_ready_low", {31'b0, txReady}, 0);
      uartTxFull = 1'b0;
      n = 0;
      while (writeCount == preW && n < 30) begin stepNeg(); n++; end
      checkOutput("tx_full_release_write", writeCount - preW, 1);
      checkOutput("tx_full_release_data", {24'b0, busWdata}, 32'h77);
      checkOutput("tx_full_write_after_decide", dataCyc - dataStatusCyc, 3);

      $display("[TB] arbitration");
      uartTxFull = 1'b1;
      repeat (4) stepNeg();
      pushTx(8'h55);
      repeat (4) stepNeg();
      kBase = accKind.size(); rBase = rxGot.size(); tBase = txLog.size();
      uartRxq.push_back(8'h11);
      uartRxq.push_back(8'h22);
      uartTxFull = 1'b0;
      pushTx(8'h66);
      n = 0;
      while ((rxGot.size() < rBase + 2 || txLog.size() < tBase + 2) && n < 100) begin
         stepNeg(); n++;
      end
      checkOutput("arb_access_count", accKind.size() - kBase, 4);
      checkOutput("arb_order_0", {24'b0, accKind[kBase]},   {24'b0, KindRead});
      checkOutput("arb_order_1", {24'b0, accKind[kBase+1]}, {24'b0, KindWrite});
      checkOutput("arb_order_2", {24'b0, accKind[kBase+2]}, {24'b0, KindRead});
      checkOutput("arb_order_3", {24'b0, accKind[kBase+3]}, {24'b0, KindWrite});
      checkOutput("arb_rx_0", {24'b0, rxGot[rBase]},   32'h11);
      checkOutput("arb_rx_1", {24'b0, rxGot[rBase+1]}, 32'h22);
      checkOutput("arb_tx_0", {24'b0, txLog[tBase]},   32'h55);
      checkOutput("arb_tx_1", {24'b0, txLog[tBase+1]}, 32'h66);

      $display("[TB] randomized traffic");
      rBase = rxGot.size(); tBase = txLog.size();
      for (int i = 0; i < 24; i++) begin
         b = 8'($urandom);
         expRx.push_back(b);
         uartRxq.push_back(b);
      end
      randomMode = 1'b1;
      for (int i = 0; i < 24; i++) begin
         repeat ($urandom_range(0, 3)) stepNeg();
         b = 8'($urandom);
         expTx.push_back(b);
         pushTx(b);
      end
      n = 0;
      while ((rxGot.size() < rBase + 24 || txLog.size() < tBase + 24) && n < 3000) begin
         stepNeg(); n++;
      end
      randomMode = 1'b0;
      stepNeg();
      rxReady = 1'b1;
      uartTxFull = 1'b0;
      checkOutput("rand_rx_count", rxGot.size() - rBase, 24);
      checkOutput("rand_tx_count", txLog.size() - tBase, 24);
      for (int i = 0; i < 24 && rBase + i < rxGot.size(); i++)
         checkOutput("rand_rx_byte", {24'b0, rxGot[rBase+i]}, {24'b0, expRx[i]});
      for (int i = 0; i < 24 && tBase + i < txLog.size(); i++)
         checkOutput("rand_tx_byte", {24'b0, txLog[tBase+i]}, {24'b0, expTx[i]});

      $display("[TB] backpressure and reset mid access");
      repeat (6) stepNeg();
      rxReady = 1'b0;
      uartTxFull = 1'b1;
      repeat (4) stepNeg();
      pushTx(8'hEE);
      preR = rxReadCount;
      preW = writeCount;
      uartRxq.push_back(8'h99);
      uartRxq.push_back(8'h9A);
      n = 0;
      while (!rxValid && n < 50) begin stepNeg(); n++; end
      repeat (20) stepNeg();
      checkOutput("bp_one_rx_read", rxReadCount - preR, 1);
      checkOutput("bp_rx_valid_held", {31'b0, rxValid}, 1);
      checkOutput("bp_rx_data_held", {24'b0, rxData}, 32'h99);
      checkOutput("bp_no_write", writeCount - preW, 0);
      checkOutput("bp_tx_ready_low", {31'b0, txReady}, 0);
      rxReady = 1'b1;
      n = 0;
      while (!(readEnable && activeAddress == 4'd0) && n < 50) begin stepNeg(); n++; end
      checkOutput("bp_second_rx_read", {31'b0, readEnable && activeAddress == 4'd0}, 1);
      checkOutput("bp_first_byte_consumed", {24'b0, rxGot[rxGot.size()-1]}, 32'h99);
      stepNeg();
      reset = 1'b1;
      #1;
      checkOutput("mid_reset_rx_valid", {31'b0, rxValid}, 0);
      checkOutput("mid_reset_read_enable", {31'b0, readEnable}, 0);
      checkOutput("mid_reset_write_enable", {31'b0, writeEnable}, 0);
      checkOutput("mid_reset_address", {28'b0, activeAddress}, 2);
      checkOutput("mid_reset_rx_data", {24'b0, rxData}, 0);
      checkOutput("mid_reset_tx_ready", {31'b0, txReady}, 1);
      repeat (2) stepNeg();
      reset = 1'b0;
      uartTxFull = 1'b0;
      preW = writeCount;
      preR = rxReadCount;
      repeat (20) stepNeg();
      checkOutput("post_reset_hold_discarded", writeCount - preW, 0);
      checkOutput("post_reset_no_rx_read", rxReadCount - preR, 0);
      checkOutput("post_reset_rx_valid", {31'b0, rxValid}, 0);
      checkOutput("post_reset_tx_ready", {31'b0, txReady}, 1);
   endtask

   initial begin
      applyStimulus();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
